// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, pixel-word layout and pipeline types for the VGA scanout.
package vga_pkg;

  localparam int unsigned DEF_PIX_DIV  = 2;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_ADDR_W   = 19;

  // Pixel word is 0x00RRGGBB; the top byte carries nothing.
  localparam int unsigned PIX_CH_W = 8;
  localparam int unsigned R_LSB    = 16;
  localparam int unsigned G_LSB    = 8;
  localparam int unsigned B_LSB    = 0;

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
    logic first;
  } pix_ctl_t;

  localparam pix_ctl_t PIX_CTL_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, first: 1'b0};

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - frame-buffer read port between scanout (master) and frame buffer (slave).
interface vga_scanout_if #(
  parameter int unsigned ADDR_W = 19
) ();

  logic              fb_ren;
  logic [ADDR_W-1:0] fb_raddr;
  logic [31:0]       fb_rdata;

  modport master (output fb_ren, output fb_raddr, input fb_rdata);
  modport slave  (input fb_ren, input fb_raddr, output fb_rdata);

endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel-rate divider, h/v position counters and raw active/sync decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic run_i,
  output logic tick_o,
  output logic div_zero_o,
  output logic active_o,
  output logic hs_o,
  output logic vs_o,
  output logic first_o,
  output logic last_o
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  // One spare code so the sync-end bound still fits when the back porch is zero.
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  assign tick_o     = run_i && (div_q == DIV_LAST);
  assign div_zero_o = (div_q == '0);
  assign active_o   = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_o       = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_o       = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign first_o    = (h_q == '0) && (v_q == '0);
  assign last_o     = (h_q == H_LAST) && (v_q == V_LAST);

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (clr_i) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else if (tick_o) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end else if (run_i) begin
      div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA scanout top: address counter, frame-buffer fetch and 2-clock sync/data alignment.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  vga_scanout_if.master        fb,
  output logic [PIX_CH_W-1:0]  vga_r,
  output logic [PIX_CH_W-1:0]  vga_g,
  output logic [PIX_CH_W-1:0]  vga_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 vga_valid,
  output logic                 frame_start
);

  logic tick, div_zero, active, hs, vs, first, last;
  logic ld0, ld1;

  logic                run_q, run_d;
  logic                ld1_q, ld1_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  pix_ctl_t            s1_q, s1_d;
  logic                valid_q, valid_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic                fs_q, fs_d;
  logic [PIX_CH_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  // run_q holds the counters at (0,0) for the clock in which enable/reset is released.
  vga_timing #(
    .PIX_DIV (PIX_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr_i     (!enable),
    .run_i     (run_q),
    .tick_o    (tick),
    .div_zero_o(div_zero),
    .active_o  (active),
    .hs_o      (hs),
    .vs_o      (vs),
    .first_o   (first),
    .last_o    (last)
  );

  assign ld0         = run_q && div_zero;
  assign ld1         = (PIX_DIV == 1) ? ld0 : ld1_q;
  assign fb.fb_ren   = ld0 && active;
  assign fb.fb_raddr = addr_q;

  always_comb begin
    run_d   = enable;
    ld1_d   = ld0;
    addr_d  = addr_q;
    s1_d    = s1_q;
    valid_d = valid_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    fs_d    = 1'b0;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    if (!enable) begin
      ld1_d   = 1'b0;
      addr_d  = '0;
      s1_d    = PIX_CTL_IDLE;
      valid_d = 1'b0;
      hs_d    = 1'b1;
      vs_d    = 1'b1;
      r_d     = '0;
      g_d     = '0;
      b_d     = '0;
    end else begin
      if (tick && last) begin
        addr_d = '0;
      end else if (tick && active) begin
        addr_d = addr_q + ADDR_W'(1);
      end
      if (ld0) begin
        s1_d = '{active: active, hs_n: hs, vs_n: vs, first: first};
      end
      // Read data arrives one clock after fb_ren, so it joins stage 1 here.
      if (ld1) begin
        valid_d = s1_q.active;
        hs_d    = s1_q.hs_n;
        vs_d    = s1_q.vs_n;
        fs_d    = s1_q.first;
        r_d     = s1_q.active ? fb.fb_rdata[R_LSB +: PIX_CH_W] : '0;
        g_d     = s1_q.active ? fb.fb_rdata[G_LSB +: PIX_CH_W] : '0;
        b_d     = s1_q.active ? fb.fb_rdata[B_LSB +: PIX_CH_W] : '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      ld1_q   <= 1'b0;
      addr_q  <= '0;
      s1_q    <= PIX_CTL_IDLE;
      valid_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      run_q   <= run_d;
      ld1_q   <= ld1_d;
      addr_q  <= addr_d;
      s1_q    <= s1_d;
      valid_q <= valid_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign vga_valid   = valid_q;
  assign frame_start = fs_q;

endmodule
